// File: rtl/median_frame_ctrl.sv
// Frame controller behind the 3x3 median filter. It tracks pixel and line position,
// latches the config at frame start, selects the output pixel and flags frame geometry errors.
module median_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_en,
  input  logic [1:0]  cfg_border,
  input  logic        err_clr,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic        in_de,
  input  logic [7:0]  in_gray,
  input  logic [7:0]  in_raw,
  output logic        out_vsync,
  output logic        out_href,
  output logic        out_de,
  output logic [7:0]  out_gray,
  output logic        frame_active,
  output logic [15:0] frame_cnt,
  output logic        err_line_len,
  output logic        err_line_cnt
);

  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [CNT_W-1:0] W_FULL = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] H_FULL = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_H - 1);

  state_t           state, state_nxt;
  logic             vsync_d, href_d, de_d;
  logic [7:0]       gray_q, pix_sel;
  logic [CNT_W-1:0] x_cnt, y_cnt, x_nxt, y_nxt;
  logic             sh_en, sh_en_nxt;
  logic [1:0]       sh_border, sh_border_nxt;
  logic [15:0]      fc_q, fc_nxt;
  logic             err_len_q, err_cnt_q;
  logic             err_len_set, err_cnt_set;
  logic             vs_rise, hr_fall, border;

  assign vs_rise = in_vsync & ~vsync_d;
  assign hr_fall = ~in_href & href_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: blocking assignments in combinational logic let the line check see the
  // count that already includes this cycle's pixel, and the frame check see the bumped line count.
  always_comb begin
    state_nxt     = state;
    x_nxt         = x_cnt;
    y_nxt         = y_cnt;
    sh_en_nxt     = sh_en;
    sh_border_nxt = sh_border;
    fc_nxt        = fc_q;
    err_len_set   = 1'b0;
    err_cnt_set   = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise) begin
          sh_en_nxt     = cfg_en;
          sh_border_nxt = cfg_border;
          x_nxt         = '0;
          y_nxt         = '0;
          state_nxt     = FRAME;
        end
      end
      FRAME: begin
        if (in_de) x_nxt = sat_inc(x_nxt);
        if (hr_fall) begin
          if (x_nxt != W_FULL) err_len_set = 1'b1;
          x_nxt = '0;
          y_nxt = sat_inc(y_nxt);
        end
        if (vs_rise) begin
          if (y_nxt != H_FULL) err_cnt_set = 1'b1;
          fc_nxt        = fc_q + 16'd1;
          sh_en_nxt     = cfg_en;
          sh_border_nxt = cfg_border;
          x_nxt         = '0;
          y_nxt         = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Border test uses the position of the current pixel, before it is counted.
  assign border = in_de && (x_cnt == '0 || x_cnt == X_LAST ||
                            y_cnt == '0 || y_cnt == Y_LAST);

  always_comb begin
    pix_sel = in_gray;
    if (!in_de) begin
      pix_sel = 8'd0;
    end else if (state == IDLE || !sh_en) begin
      pix_sel = in_raw;
    end else if (border) begin
      case (sh_border)
        2'd1:    pix_sel = 8'd0;
        2'd2:    pix_sel = in_gray;
        default: pix_sel = in_raw;
      endcase
    end
  end

  // NOTE: reset is synchronous; it is sampled only on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vsync_d   <= 1'b0;
      href_d    <= 1'b0;
      de_d      <= 1'b0;
      gray_q    <= 8'd0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      sh_en     <= 1'b0;
      sh_border <= 2'd0;
      fc_q      <= 16'd0;
      err_len_q <= 1'b0;
      err_cnt_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      vsync_d   <= in_vsync;
      href_d    <= in_href;
      de_d      <= in_de;
      gray_q    <= pix_sel;
      x_cnt     <= x_nxt;
      y_cnt     <= y_nxt;
      sh_en     <= sh_en_nxt;
      sh_border <= sh_border_nxt;
      fc_q      <= fc_nxt;
      // A new error in the same cycle as a clear must survive.
      err_len_q <= err_len_set | (err_len_q & ~err_clr);
      err_cnt_q <= err_cnt_set | (err_cnt_q & ~err_clr);
    end
  end

  assign out_vsync    = vsync_d;
  assign out_href     = href_d;
  assign out_de       = de_d;
  assign out_gray     = gray_q;
  assign frame_active = (state == FRAME);
  assign frame_cnt    = fc_q;
  assign err_line_len = err_len_q;
  assign err_line_cnt = err_cnt_q;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Directed bench for median_frame_ctrl on a small 8x4 image: border selection,
// config latching at frame boundaries, geometry errors and mid-line reset.
module tb_median_frame_ctrl;

  localparam int W = 8;
  localparam int H = 4;
  localparam logic [7:0] GRAY = 8'h80;
  localparam logic [7:0] RAW  = 8'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [1:0]  cfg_border;
  logic        err_clr;
  logic        in_vsync, in_href, in_de;
  logic [7:0]  in_gray, in_raw;
  logic        out_vsync, out_href, out_de;
  logic [7:0]  out_gray;
  logic        frame_active;
  logic [15:0] frame_cnt;
  logic        err_line_len, err_line_cnt;

  int checks = 0;
  int errors = 0;

  // Bench-side frame model
  bit in_frame     = 1'b0;
  int exp_fc       = 0;
  int prev_lines   = 0;
  bit exp_err_len  = 1'b0;
  bit exp_err_cnt  = 1'b0;

  median_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_border(cfg_border), .err_clr(err_clr),
    .in_vsync(in_vsync), .in_href(in_href), .in_de(in_de), .in_gray(in_gray), .in_raw(in_raw),
    .out_vsync(out_vsync), .out_href(out_href), .out_de(out_de), .out_gray(out_gray),
    .frame_active(frame_active), .frame_cnt(frame_cnt),
    .err_line_len(err_line_len), .err_line_cnt(err_line_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_pix(input bit en, input logic [1:0] bmode,
                                         input int x, input int y);
    bit b;
    b = (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
    if (!en) return RAW;
    if (!b) return GRAY;
    case (bmode)
      2'd1:    return 8'h00;
      2'd2:    return GRAY;
      default: return RAW;
    endcase
  endfunction

  // vsync pulse, nlines lines (line short_idx one pixel short), cfg_en <= mid_en from line 1 on
  task automatic send_frame(input int nlines, input int short_idx, input bit exp_en,
                            input logic [1:0] exp_b, input bit mid_en, input bit clr_on_short);
    int w;
    in_vsync = 1'b1;
    cycle();
    if (in_frame) begin
      exp_fc++;
      if (prev_lines != H) exp_err_cnt = 1'b1;
    end
    in_frame = 1'b1;
    check("vsync_dly", out_vsync, 1);
    check("frame_cnt", frame_cnt, exp_fc);
    check("err_line_cnt", err_line_cnt, exp_err_cnt);
    check("frame_active", frame_active, 1);
    in_vsync = 1'b0;
    cycle();
    check("vsync_low", out_vsync, 0);
    for (int l = 0; l < nlines; l++) begin
      if (l == 1) cfg_en = mid_en;
      w = (l == short_idx) ? W - 1 : W;
      for (int x = 0; x < w; x++) begin
        in_href = 1'b1;
        in_de   = 1'b1;
        cycle();
        if (x == 0) check("href_dly", out_href, 1);
        check("de_dly", out_de, 1);
        check($sformatf("pix_y%0d_x%0d", l, x), out_gray, exp_pix(exp_en, exp_b, x, l));
      end
      in_href = 1'b0;
      in_de   = 1'b0;
      if (l == short_idx) begin
        exp_err_len = 1'b1;
        if (clr_on_short) err_clr = 1'b1;
      end
      cycle();
      err_clr = 1'b0;
      check("err_line_len", err_line_len, exp_err_len);
      check("gap_gray", out_gray, 0);
      check("gap_de", out_de, 0);
      cycle();
    end
    prev_lines = nlines;
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b1; cfg_border = 2'd0; err_clr = 1'b0;
    in_vsync = 1'b0; in_href = 1'b0; in_de = 1'b0; in_gray = GRAY; in_raw = RAW;
    repeat (3) cycle();
    check("rst_gray", out_gray, 0);
    check("rst_fc", frame_cnt, 0);
    check("rst_active", frame_active, 0);
    check("rst_errs", {err_line_len, err_line_cnt}, 0);
    rst = 1'b0;
    cycle();

    // Two frames with raw borders, then zero and filtered borders
    send_frame(H, -1, 1'b1, 2'd0, 1'b1, 1'b0);
    send_frame(H, -1, 1'b1, 2'd0, 1'b1, 1'b0);
    cfg_border = 2'd1;
    send_frame(H, -1, 1'b1, 2'd1, 1'b1, 1'b0);
    cfg_border = 2'd2;
    send_frame(H, -1, 1'b1, 2'd2, 1'b1, 1'b0);
    cfg_border = 2'd3;
    send_frame(H, -1, 1'b1, 2'd3, 1'b1, 1'b0);
    cfg_border = 2'd0;

    // Bypass requested mid-frame: takes effect one frame later
    send_frame(H, -1, 1'b1, 2'd0, 1'b0, 1'b0);
    send_frame(H, -1, 1'b0, 2'd0, 1'b0, 1'b0);
    cfg_en = 1'b1;

    // Short line, then a short line with a simultaneous clear, then a lone clear
    send_frame(H, 1, 1'b1, 2'd0, 1'b1, 1'b0);
    send_frame(H, 2, 1'b1, 2'd0, 1'b1, 1'b1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    exp_err_len = 1'b0;
    check("err_len_clr", err_line_len, 0);

    // Three-line frame flagged at the following frame start
    send_frame(3, -1, 1'b1, 2'd0, 1'b1, 1'b0);
    send_frame(H, -1, 1'b1, 2'd0, 1'b1, 1'b0);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    exp_err_cnt = 1'b0;
    check("err_cnt_clr", err_line_cnt, 0);

    // Reset in the middle of a line
    in_vsync = 1'b1; cycle();
    in_vsync = 1'b0; cycle();
    in_href = 1'b1; in_de = 1'b1;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    check("mid_rst_gray", out_gray, 0);
    check("mid_rst_de", out_de, 0);
    check("mid_rst_href", out_href, 0);
    check("mid_rst_fc", frame_cnt, 0);
    check("mid_rst_active", frame_active, 0);
    rst = 1'b0;
    in_frame = 1'b0; exp_fc = 0; exp_err_len = 1'b0; exp_err_cnt = 1'b0; prev_lines = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("idle_raw", out_gray, RAW);
    end
    in_href = 1'b0; in_de = 1'b0;
    cycle();
    check("idle_errs", {err_line_len, err_line_cnt}, 0);
    check("idle_fc", frame_cnt, 0);
    cycle();
    send_frame(H, -1, 1'b1, 2'd0, 1'b1, 1'b0);
    send_frame(H, -1, 1'b1, 2'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
